icache_refill_packer: RTL and testbench
=======================================

// Module: icache_refill_packer
// PURPOSE
//  Sits directly upstream of the icache dual-port RAM (read port A, write port B with bit-write enable).
//  Packs BEAT_WIDTH refill beats from the memory side into one DATA_WIDTH line and issues a single write on port B.
//  Passes fetch reads to port A and stalls a read that collides with the write-cycle address.
//  Drives CEA/AA and CEB/AB/DB/BWB of the RAM wrapper and returns QA to the fetch side.
// PARAMETERS
//  ADDR_WIDTH  7    line index width (RAM depth = 2**ADDR_WIDTH)
//  DATA_WIDTH  256  line width; must be an integer multiple of BEAT_WIDTH
//  BEAT_WIDTH  64   refill beat width; BEATS = DATA_WIDTH/BEAT_WIDTH (>=2)
// PORTS
//  clk_i           in   1           clock; RAM CLKA/CLKB are tied to it outside this block
//  rst_i           in   1           reset, asynchronous, active-high
//  refill_valid_i  in   1           refill beat valid
//  refill_ready_o  out  1           beat accepted when valid & ready
//  refill_addr_i   in   ADDR_WIDTH  line index; sampled on the first beat of a line only
//  refill_data_i   in   BEAT_WIDTH  beat data; beat k fills bits [k*BEAT_WIDTH +: BEAT_WIDTH]
//  refill_last_i   in   1           last beat of line (may arrive early: partial line)
//  flush_i         in   1           abort the line being filled
//  rd_req_i        in   1           fetch read request
//  rd_addr_i       in   ADDR_WIDTH  fetch read index
//  rd_ready_o      out  1           read accepted when rd_req_i & rd_ready_o
//  rd_valid_o      out  1           read data valid, 1 cycle after acceptance
//  rd_data_o       out  DATA_WIDTH  read data (= ram_qa_i)
//  ram_cea_o       out  1           RAM read enable, 1 = read
//  ram_aa_o        out  ADDR_WIDTH  RAM read address
//  ram_qa_i        in   DATA_WIDTH  RAM read data
//  ram_ceb_o       out  1           RAM write enable, 1 = write
//  ram_ab_o        out  ADDR_WIDTH  RAM write address
//  ram_db_o        out  DATA_WIDTH  RAM write data
//  ram_bwb_o       out  DATA_WIDTH  RAM bit-write enable, 1 = write bit
// BEHAVIOUR
//  Reset: state=IDLE, beat counter=0, line buffer and mask=0, rd_valid_o=0, ram_ceb_o=0; outputs derived from these.
//  FSM: IDLE -> FILL on the first accepted beat (no last); IDLE -> WRITE on the first accepted beat with last.
//   FILL -> WRITE on an accepted beat with refill_last_i, or on acceptance of beat BEATS-1 (implicit last).
//   FILL -> IDLE on flush_i: buffer, mask, and counter are cleared; no write is issued.
//   WRITE -> IDLE after exactly one cycle; flush_i is ignored in WRITE.
//  refill_ready_o = (state != WRITE) & ~flush_i; a beat presented together with flush_i is not accepted.
//  Each accepted beat k writes buffer slice k and sets mask slice k to all-ones; the counter increments and never exceeds BEATS-1.
//  Address is captured on beat 0; refill_addr_i on later beats is ignored.
//  WRITE cycle: ram_ceb_o=1, ram_ab_o=captured addr, ram_db_o=buffer, ram_bwb_o=mask.
//   Slices not received keep their mask=0, so the RAM retains the old data there.
//   ram_ceb_o=0 in all other states.
//  ram_ab_o, ram_db_o, and ram_bwb_o are registered; ram_ceb_o is asserted exactly one cycle per line.
//  Refill-beat-to-write latency: 1 cycle after the accepting edge of the last beat.
//  Read path: rd_ready_o = ~(state==WRITE & rd_addr_i==captured addr).
//   ram_cea_o = rd_req_i & rd_ready_o; ram_aa_o = rd_addr_i (combinational).
//   rd_valid_o is a registered copy of ram_cea_o; rd_data_o = ram_qa_i.
//  A read to a different index in the WRITE cycle proceeds in parallel with the write.
//  A read to the line currently in FILL is not stalled and returns the old RAM contents.
//  Reset mid-FILL or mid-WRITE: the partial line is dropped; ram_ceb_o deasserts asynchronously; no write completes afterwards.
//  Back-to-back lines: a beat offered in the WRITE cycle waits; beat 0 of the next line is accepted in the following cycle.
// TESTING
//  T1: 4 beats (256/64) to addr 0x12, last on beat 3 -> one cycle later ceb=1, ab=0x12, bwb all-ones, db = {b3,b2,b1,b0}.
//  T2: 2 beats to addr 0x05, last on beat 1 -> bwb[127:0]=1 and bwb[255:128]=0; readback shows old upper half.
//  T3: rd_req to 0x12 in the WRITE cycle of T1 -> rd_ready_o=0, cea=0; accepted next cycle, rd_valid 1 cycle later with new data.
//  T4: flush_i after 2 beats -> no ceb pulse; the next line starts at beat 0 with the new address.
//  T5: rst_i asserted mid-FILL (beat 2) -> refill_ready=1, ceb=0, rd_valid=0 immediately; no write ever issued.
//  T6: 4 beats, no refill_last_i, then 4 more beats -> two ceb pulses; the 5th beat is stalled exactly 1 cycle.

Source files
------------

// File: rtl/icache_refill_packer.sv
// Packs refill beats into one icache line and writes it through RAM port B with a bit mask;
// forwards fetch reads to port A and stalls a read that hits the line being written.
module icache_refill_packer #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  refill_valid_i,
  output logic                  refill_ready_o,
  input  logic [ADDR_WIDTH-1:0] refill_addr_i,
  input  logic [BEAT_WIDTH-1:0] refill_data_i,
  input  logic                  refill_last_i,
  input  logic                  flush_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ready_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  ram_cea_o,
  output logic [ADDR_WIDTH-1:0] ram_aa_o,
  input  logic [DATA_WIDTH-1:0] ram_qa_i,
  output logic                  ram_ceb_o,
  output logic [ADDR_WIDTH-1:0] ram_ab_o,
  output logic [DATA_WIDTH-1:0] ram_db_o,
  output logic [DATA_WIDTH-1:0] ram_bwb_o
);

  localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   line_buf;
  logic [DATA_WIDTH-1:0]   line_mask;
  logic [ADDR_WIDTH-1:0]   line_addr;
  logic                    beat_acc;
  logic                    beat_end;

  assign refill_ready_o = (state != WRITE) && !flush_i;
  assign beat_acc       = refill_valid_i && refill_ready_o;
  assign beat_end       = refill_last_i || (cnt == CNT_W'(BEATS - 1));

  assign rd_ready_o = !((state == WRITE) && (rd_addr_i == line_addr));
  assign ram_cea_o  = rd_req_i && rd_ready_o;
  assign ram_aa_o   = rd_addr_i;
  assign rd_data_o  = ram_qa_i;

  // Line registers feed port B directly; ram_ceb_o qualifies them for exactly one cycle.
  assign ram_ab_o  = line_addr;
  assign ram_db_o  = line_buf;
  assign ram_bwb_o = line_mask;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      line_buf   <= '0;
      line_mask  <= '0;
      line_addr  <= '0;
      ram_ceb_o  <= 1'b0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= ram_cea_o;
      ram_ceb_o  <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if ((state == FILL) && flush_i) begin
            state     <= IDLE;
            cnt       <= '0;
            line_buf  <= '0;
            line_mask <= '0;
          end else if (beat_acc) begin
            line_buf[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH]  <= refill_data_i;
            line_mask[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH] <= '1;
            if (state == IDLE) line_addr <= refill_addr_i;
            if (beat_end) begin
              state     <= WRITE;
              ram_ceb_o <= 1'b1;
            end else begin
              state <= FILL;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          // Clear after the write so the next (possibly partial) line starts with an empty mask.
          state     <= IDLE;
          cnt       <= '0;
          line_buf  <= '0;
          line_mask <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_packer.sv
// Bench for icache_refill_packer: behavioural RAM on ports A/B, scoreboard queues for
// expected writes and reads, a table of line transactions plus hand-written corner sequences.
module tb_icache_refill_packer;

  localparam int AW    = 7;
  localparam int DW    = 256;
  localparam int BW    = 64;
  localparam int BEATS = DW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          refill_valid, refill_ready, refill_last, flush;
  logic [AW-1:0] refill_addr;
  logic [BW-1:0] refill_data;
  logic          rd_req, rd_ready, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          ram_cea, ram_ceb;
  logic [AW-1:0] ram_aa, ram_ab;
  logic [DW-1:0] ram_qa, ram_db, ram_bwb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   nbeats;
    logic          explicit_last;
    logic [DW-1:0] exp_mask;
  } vec_t;

  wr_t           exp_wq[$];
  logic [DW-1:0] exp_rq[$];
  logic [DW-1:0] mem[128];
  logic [DW-1:0] ref_mem[128];
  logic          mem_init_done = 1'b0;
  vec_t          vecs[5];

  icache_refill_packer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEAT_WIDTH(BW)) dut (
    .clk_i(clk), .rst_i(rst),
    .refill_valid_i(refill_valid), .refill_ready_o(refill_ready),
    .refill_addr_i(refill_addr), .refill_data_i(refill_data),
    .refill_last_i(refill_last), .flush_i(flush),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .ram_cea_o(ram_cea), .ram_aa_o(ram_aa), .ram_qa_i(ram_qa),
    .ram_ceb_o(ram_ceb), .ram_ab_o(ram_ab), .ram_db_o(ram_db), .ram_bwb_o(ram_bwb)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with bit-write enable on port B.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      mem           <= ref_mem;
      mem_init_done <= 1'b1;
    end else begin
      if (ram_cea) ram_qa <= mem[ram_aa];
      if (ram_ceb) mem[ram_ab] <= (mem[ram_ab] & ~ram_bwb) | (ram_db & ram_bwb);
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_ceb) begin
        checks++;
        if (exp_wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: ab=%h expected no write", ram_ab);
        end else begin
          wr_t e;
          e = exp_wq.pop_front();
          if (ram_ab !== e.addr || ram_bwb !== e.mask || (ram_db & e.mask) !== (e.data & e.mask)) begin
            errors++;
            $display("FAIL write: ab=%h bwb=%h db=%h expected ab=%h bwb=%h db=%h",
                     ram_ab, ram_bwb, ram_db & e.mask, e.addr, e.mask, e.data & e.mask);
          end
          ref_mem[e.addr] = (ref_mem[e.addr] & ~e.mask) | (e.data & e.mask);
        end
      end
      if (rd_valid) begin
        checks++;
        if (exp_rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_valid: data=%h expected no read", rd_data);
        end else begin
          logic [DW-1:0] r;
          r = exp_rq.pop_front();
          if (rd_data !== r) begin
            errors++;
            $display("FAIL read_data: got %h expected %h", rd_data, r);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one beat until accepted; returns at posedge+1 of the accepting edge with valid still high.
  task automatic send_beat(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic last,
                           output int stalls);
    logic acc;
    acc = 1'b0;
    refill_valid = 1'b1;
    refill_addr  = a;
    refill_data  = d;
    refill_last  = last;
    stalls       = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      acc = refill_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      stalls++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got no acceptance expected acceptance within 20 cycles");
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int stalls);
    logic acc;
    acc = 1'b0;
    rd_req  = 1'b1;
    rd_addr = a;
    stalls  = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      acc = rd_ready;
      if (acc) exp_rq.push_back(ref_mem[a]);
      @(posedge clk);
      #1;
      if (acc) break;
      stalls++;
    end
    rd_req = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got no acceptance expected acceptance within 20 cycles");
    end
  endtask

  task automatic send_line(input logic [AW-1:0] a, input int unsigned nbeats, input logic explicit_last,
                           input logic [DW-1:0] mask, output int first_stalls);
    logic [BW-1:0] beats[BEATS];
    logic [DW-1:0] data;
    wr_t           e;
    int            s;
    data = '0;
    for (int unsigned k = 0; k < nbeats; k++) begin
      beats[k] = {$urandom(), $urandom()};
      data[BW*k +: BW] = beats[k];
    end
    first_stalls = 0;
    for (int unsigned k = 0; k < nbeats; k++) begin
      if (k == nbeats - 1) begin
        e.addr = a; e.data = data; e.mask = mask;
        exp_wq.push_back(e);
      end
      // Later beats carry a junk address that must be ignored.
      send_beat((k == 0) ? a : AW'($urandom()), beats[k], explicit_last && (k == nbeats - 1), s);
      if (k == 0) first_stalls = s;
    end
    refill_valid = 1'b0;
    refill_last  = 1'b0;
  endtask

  initial begin
    int s;
    for (int i = 0; i < 128; i++)
      for (int w = 0; w < DW / 32; w++) ref_mem[i][32*w +: 32] = $urandom();

    vecs[0] = '{addr: 7'h12, nbeats: 4, explicit_last: 1'b1, exp_mask: {256{1'b1}}};
    vecs[1] = '{addr: 7'h05, nbeats: 2, explicit_last: 1'b1, exp_mask: {{128{1'b0}}, {128{1'b1}}}};
    vecs[2] = '{addr: 7'h33, nbeats: 1, explicit_last: 1'b1, exp_mask: {{192{1'b0}}, {64{1'b1}}}};
    vecs[3] = '{addr: 7'h7f, nbeats: 3, explicit_last: 1'b1, exp_mask: {{64{1'b0}}, {192{1'b1}}}};
    vecs[4] = '{addr: 7'h00, nbeats: 4, explicit_last: 1'b0, exp_mask: {256{1'b1}}};

    rst = 1'b1;
    refill_valid = 1'b0; refill_last = 1'b0; flush = 1'b0;
    refill_addr = '0; refill_data = '0; rd_req = 1'b0; rd_addr = '0;
    #23;
    check("reset_refill_ready", refill_ready, 1);
    check("reset_ceb", ram_ceb, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_bwb", ram_bwb, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Table: each line, then a same-index read issued in its WRITE cycle.
    for (int i = 0; i < 5; i++) begin
      send_line(vecs[i].addr, vecs[i].nbeats, vecs[i].explicit_last, vecs[i].exp_mask, s);
      check("write_latency_ceb", ram_ceb, 1);
      rd_req = 1'b1; rd_addr = vecs[i].addr;
      #1;
      check("write_collide_rd_ready", rd_ready, 0);
      check("write_collide_cea", ram_cea, 0);
      do_read(vecs[i].addr, s);
      check("write_collide_stall_cycles", s, 1);
      idle(2);
    end

    // Read during FILL, then flush: no write; the next line restarts at beat 0.
    send_beat(7'h21, {$urandom(), $urandom()}, 1'b0, s);
    refill_valid = 1'b0;
    do_read(7'h21, s);
    check("fill_read_stall_cycles", s, 0);
    send_beat(7'h21, {$urandom(), $urandom()}, 1'b0, s);
    flush = 1'b1;
    #1;
    check("flush_refill_ready", refill_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; refill_valid = 1'b0;
    idle(3);
    send_line(7'h22, 2, 1'b1, {{128{1'b0}}, {128{1'b1}}}, s);
    do_read(7'h05, s);
    check("parallel_read_stall_cycles", s, 0);
    do_read(7'h21, s);
    idle(2);

    // Reset mid-FILL with a read in flight, then reset mid-WRITE.
    send_beat(7'h30, {$urandom(), $urandom()}, 1'b0, s);
    rd_req = 1'b1; rd_addr = 7'h01;
    send_beat(7'h30, {$urandom(), $urandom()}, 1'b0, s);
    rd_req = 1'b0;
    check("pre_rst_rd_valid", rd_valid, 1);
    refill_data = {$urandom(), $urandom()};
    #2 rst = 1'b1;
    #1;
    check("rst_fill_refill_ready", refill_ready, 1);
    check("rst_fill_ceb", ram_ceb, 0);
    check("rst_fill_rd_valid", rd_valid, 0);
    refill_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    for (int k = 0; k < BEATS; k++) send_beat(7'h31, {$urandom(), $urandom()}, 1'b0, s);
    refill_valid = 1'b0;
    check("pre_rst_write_ceb", ram_ceb, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_write_ceb", ram_ceb, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    do_read(7'h30, s);
    do_read(7'h31, s);
    idle(2);

    // Back-to-back implicit-last lines: first beat of the second line waits one cycle.
    send_line(7'h50, 4, 1'b0, {256{1'b1}}, s);
    send_line(7'h51, 4, 1'b0, {256{1'b1}}, s);
    check("back_to_back_stall_cycles", s, 1);
    idle(2);
    do_read(7'h50, s);
    do_read(7'h51, s);
    idle(4);

    check("pending_writes", exp_wq.size(), 0);
    check("pending_reads", exp_rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
